// File: rtl/raymarcher_core.sv
// Fully pipelined per-pixel raymarcher against an origin-centred cube; one pixel/clk, latency MAX_STEPS+3.
// Optional macro RM_STEP_SHADING_EN: grey hit colour by march step (flat white when undefined).
module raymarcher_core #(
  parameter int               MAX_STEPS = 8,
  parameter logic signed [26:0] BOX_HALF  = 27'sh0100000,
  parameter logic signed [26:0] HIT_EPS   = 27'sh0000400,
  parameter logic signed [26:0] FAR_DIST  = 27'sh2000000,
  parameter logic signed [26:0] FOCAL     = 27'sh0100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [26:0] eye_x,
  input  logic [26:0] eye_y,
  input  logic [26:0] eye_z,
  input  logic [26:0] look_at_1_1,
  input  logic [26:0] look_at_1_2,
  input  logic [26:0] look_at_1_3,
  input  logic [26:0] look_at_2_1,
  input  logic [26:0] look_at_2_2,
  input  logic [26:0] look_at_2_3,
  input  logic [26:0] look_at_3_1,
  input  logic [26:0] look_at_3_2,
  input  logic [26:0] look_at_3_3,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam int STEP_SHADE = 256 / MAX_STEPS;

  typedef logic signed [26:0] q_t;

  localparam q_t Q_MAX = 27'sh3FFFFFF;
  localparam q_t Q_MIN = 27'sh4000000;

  typedef struct packed {
    logic          vis;
    logic          hit;
    logic          esc;
    logic [SW-1:0] step;
    q_t            px;
    q_t            py;
    q_t            pz;
    q_t            dx;
    q_t            dy;
    q_t            dz;
  } ray_t;

  function automatic q_t q_sat(input logic signed [54:0] v);
    if (v > 55'sd67108863)       return Q_MAX;
    else if (v < -55'sd67108864) return Q_MIN;
    else                         return v[26:0];
  endfunction

  function automatic q_t q_add(input q_t a, input q_t b);
    return q_sat(55'(a) + 55'(b));
  endfunction

  function automatic q_t q_sub(input q_t a, input q_t b);
    return q_sat(55'(a) - 55'(b));
  endfunction

  function automatic q_t q_mul(input q_t a, input q_t b);
    logic signed [53:0] prod;
    prod = 54'(a) * 54'(b);
    return q_sat(55'(prod >>> 20));
  endfunction

  function automatic q_t q_abs(input q_t a);
    return (a < 0) ? q_sat(-55'(a)) : a;
  endfunction

  function automatic q_t q_max(input q_t a, input q_t b);
    return (a > b) ? a : b;
  endfunction

  // One sphere-tracing step with the Chebyshev box distance; finished rays pass through untouched.
  function automatic ray_t march(input ray_t r, input logic [SW-1:0] k);
    ray_t n;
    q_t   d;
    n = r;
    d = q_sub(q_max(q_max(q_abs(r.px), q_abs(r.py)), q_abs(r.pz)), BOX_HALF);
    if (!(r.hit || r.esc)) begin
      if (d < HIT_EPS) begin
        n.hit  = 1'b1;
        n.step = k;
      end else if (d > FAR_DIST) begin
        n.esc = 1'b1;
      end else begin
        n.px = q_add(r.px, q_mul(d, r.dx));
        n.py = q_add(r.py, q_mul(d, r.dy));
        n.pz = q_add(r.pz, q_mul(d, r.dz));
      end
    end
    return n;
  endfunction

  // Stage S0: screen coordinates to camera-local plane, inputs captured alongside
  q_t   eye_in [3];
  q_t   m_in   [9];
  q_t   u_d, v_d;
  logic vis_d;

  assign eye_in = '{eye_x, eye_y, eye_z};
  assign m_in   = '{look_at_1_1, look_at_1_2, look_at_1_3,
                    look_at_2_1, look_at_2_2, look_at_2_3,
                    look_at_3_1, look_at_3_2, look_at_3_3};
  assign u_d    = ($signed({17'd0, pixel_x}) - 27'sd320) <<< 11;
  assign v_d    = (27'sd240 - $signed({17'd0, pixel_y})) <<< 11;
  assign vis_d  = (pixel_x < 10'd640) && (pixel_y < 10'd480);

  logic vis_q;
  q_t   u_q, v_q;
  q_t   eye_q [3];
  q_t   m_q   [9];

  // Stage S1: rotate local ray (u, v, FOCAL) into world space
  q_t   dir_d [3];
  ray_t s1_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dir
    assign dir_d[gi] = q_add(q_add(q_mul(m_q[gi*3+0], u_q), q_mul(m_q[gi*3+1], v_q)),
                             q_mul(m_q[gi*3+2], FOCAL));
  end

  always_comb begin
    s1_d     = '0;
    s1_d.vis = vis_q;
    s1_d.px  = eye_q[0];
    s1_d.py  = eye_q[1];
    s1_d.pz  = eye_q[2];
    s1_d.dx  = dir_d[0];
    s1_d.dy  = dir_d[1];
    s1_d.dz  = dir_d[2];
  end

  // March stages: ray_q[0] is the S1 register, ray_q[k+1] the result of step k
  ray_t ray_q   [0:MAX_STEPS];
  ray_t march_d [0:MAX_STEPS-1];

  for (genvar gi = 0; gi < MAX_STEPS; gi++) begin : g_march
    assign march_d[gi] = march(ray_q[gi], SW'(gi));
  end

  // Final colour stage
  ray_t        last_ray;
  logic [23:0] rgb_d, rgb_q;

  assign last_ray = ray_q[MAX_STEPS];

  always_comb begin
    rgb_d = 24'h000000;
    if (!last_ray.vis) begin
      rgb_d = 24'h000000;
    end else if (!last_ray.hit) begin
      rgb_d = 24'h103070;
    end else begin
`ifdef RM_STEP_SHADING_EN
      rgb_d = {3{8'(255 - int'(last_ray.step) * STEP_SHADE)}};
`else
      rgb_d = 24'hFFFFFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vis_q <= 1'b0;
      u_q   <= '0;
      v_q   <= '0;
      for (int i = 0; i < 3; i++) eye_q[i] <= '0;
      for (int i = 0; i < 9; i++) m_q[i] <= '0;
      for (int i = 0; i <= MAX_STEPS; i++) ray_q[i] <= '0;
      rgb_q <= '0;
    end else begin
      vis_q <= vis_d;
      u_q   <= u_d;
      v_q   <= v_d;
      for (int i = 0; i < 3; i++) eye_q[i] <= eye_in[i];
      for (int i = 0; i < 9; i++) m_q[i] <= m_in[i];
      ray_q[0] <= s1_d;
      for (int i = 0; i < MAX_STEPS; i++) ray_q[i+1] <= march_d[i];
      rgb_q <= rgb_d;
    end
  end

  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];

endmodule

// File: tb/tb_raymarcher_core.sv
// Bench for raymarcher_core: directed scene checks plus randomized cameras against a behavioural model.
// Honours RM_STEP_SHADING_EN the same way as the design.
module tb_raymarcher_core;

  localparam longint QMAX  = 64'sd67108863;
  localparam longint QMIN  = -64'sd67108864;
  localparam longint ONE   = 64'sd1048576;
  localparam longint BOX   = ONE;
  localparam longint EPS   = 64'sd1024;
  localparam longint FAR   = 32 * ONE;
  localparam longint FOC   = ONE;
  localparam int     LAT   = 11;
  localparam logic [23:0] BG_C = 24'h103070;
`ifdef RM_STEP_SHADING_EN
  localparam logic [23:0] HIT_C = 24'hDFDFDF;
`else
  localparam logic [23:0] HIT_C = 24'hFFFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic [26:0] eye_arr [3];
  logic [26:0] m_arr   [9];
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  raymarcher_core dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .eye_x(eye_arr[0]), .eye_y(eye_arr[1]), .eye_z(eye_arr[2]),
    .look_at_1_1(m_arr[0]), .look_at_1_2(m_arr[1]), .look_at_1_3(m_arr[2]),
    .look_at_2_1(m_arr[3]), .look_at_2_2(m_arr[4]), .look_at_2_3(m_arr[5]),
    .look_at_3_1(m_arr[6]), .look_at_3_2(m_arr[7]), .look_at_3_3(m_arr[8]),
    .red(red), .green(green), .blue(blue)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [23:0] exp_pipe [LAT];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > QMAX) return QMAX;
    if (v < QMIN) return QMIN;
    return v;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return sat((a * b) >>> 20);
  endfunction

  function automatic longint sx(input logic [26:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint fabs(input longint v);
    return sat(v < 0 ? -v : v);
  endfunction

  // Marches the ray for the current inputs directly from the scene description.
  function automatic logic [23:0] ref_colour();
    longint dir [3];
    longint p   [3];
    longint u, v, d, a;
    bit     hit, esc;
    int     step;
    logic [7:0] g;
    hit = 0; esc = 0; step = 0;
    if (pixel_x >= 640 || pixel_y >= 480) return 24'h000000;
    u = (longint'(pixel_x) - 320) * 2048;
    v = (240 - longint'(pixel_y)) * 2048;
    for (int i = 0; i < 3; i++) begin
      dir[i] = sat(sat(fmul(sx(m_arr[i*3]), u) + fmul(sx(m_arr[i*3+1]), v))
                   + fmul(sx(m_arr[i*3+2]), FOC));
      p[i] = sx(eye_arr[i]);
    end
    for (int k = 0; k < 8; k++) begin
      if (!hit && !esc) begin
        a = fabs(p[0]);
        if (fabs(p[1]) > a) a = fabs(p[1]);
        if (fabs(p[2]) > a) a = fabs(p[2]);
        d = sat(a - BOX);
        if (d < EPS) begin
          hit = 1; step = k;
        end else if (d > FAR) begin
          esc = 1;
        end else begin
          for (int i = 0; i < 3; i++) p[i] = sat(p[i] + fmul(d, dir[i]));
        end
      end
    end
    if (!hit) return BG_C;
`ifdef RM_STEP_SHADING_EN
    g = 8'(255 - step * 32);
    return {g, g, g};
`else
    g = 8'hFF;
    return {g, g, g};
`endif
  endfunction

  task automatic step_clk(input string tag);
    logic [23:0] c;
    c = rst ? 24'h000000 : ref_colour();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      for (int i = 0; i < LAT; i++) exp_pipe[i] = 24'h0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) exp_pipe[i] = exp_pipe[i-1];
      exp_pipe[0] = c;
    end
    check_val(tag, 32'({red, green, blue}), 32'(exp_pipe[LAT-1]));
    $display("cyc=%0d rst=%0d px=(%0d,%0d) rgb=%06h", cyc, rst, pixel_x, pixel_y, {red, green, blue});
  endtask

  task automatic default_cam();
    eye_arr[0] = '0;
    eye_arr[1] = '0;
    eye_arr[2] = 27'h7C00000;
    for (int i = 0; i < 9; i++) m_arr[i] = (i % 4 == 0) ? 27'h0100000 : 27'h0;
  endtask

  task automatic rand_cam();
    longint r;
    if ($urandom_range(0, 1) == 1) begin
      default_cam();
      for (int i = 0; i < 3; i++) begin
        r = sx(eye_arr[i]) + longint'($urandom_range(0, 1048576)) - 524288;
        eye_arr[i] = r[26:0];
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r = longint'($urandom_range(0, 12582912)) - 6291456;
        eye_arr[i] = r[26:0];
      end
      for (int i = 0; i < 9; i++) begin
        r = longint'($urandom_range(0, 3145728)) - 1572864;
        m_arr[i] = r[26:0];
      end
    end
  endtask

  task automatic rand_pixel();
    pixel_x = 10'($urandom_range(0, 767));
    pixel_y = 10'($urandom_range(0, 543));
  endtask

  int          dir_x [10] = '{320, 0, 700, 100, 320, 0, 320, 0, 320, 0};
  int          dir_y [10] = '{240, 0, 10, 500, 240, 0, 240, 0, 240, 0};
  logic [23:0] dir_e [10];

  initial begin
    dir_e = '{HIT_C, BG_C, 24'h0, 24'h0, HIT_C, BG_C, HIT_C, BG_C, HIT_C, BG_C};
    for (int i = 0; i < LAT; i++) exp_pipe[i] = 24'h0;
    rst = 1'b1;
    pixel_x = 10'd320;
    pixel_y = 10'd240;
    default_cam();
    repeat (3) step_clk("reset_hold");
    check_val("reset_state", 32'({red, green, blue}), 32'h0);

    // Directed scene, then throughput alternation; first LAT-1 outputs must stay dark
    rst = 1'b0;
    for (int i = 0; i < 10 + LAT - 1; i++) begin
      pixel_x = (i < 10) ? 10'(dir_x[i]) : 10'd0;
      pixel_y = (i < 10) ? 10'(dir_y[i]) : 10'd0;
      step_clk("dir_model");
      if (i >= LAT - 1) check_val("dir_const", 32'({red, green, blue}), 32'(dir_e[i-(LAT-1)]));
      else              check_val("post_rst_zero", 32'({red, green, blue}), 32'h0);
    end

    // Camera looking down +x with rows x/z swapped
    eye_arr[0] = 27'h7C00000;
    eye_arr[1] = '0;
    eye_arr[2] = '0;
    for (int i = 0; i < 9; i++) m_arr[i] = '0;
    m_arr[2] = 27'h0100000;
    m_arr[4] = 27'h0100000;
    m_arr[6] = 27'h0100000;
    pixel_x = 10'd320;
    pixel_y = 10'd240;
    for (int i = 0; i < LAT; i++) step_clk("swap_model");
    check_val("swap_hit", 32'({red, green, blue}), 32'(HIT_C));

    // Asynchronous reset in the middle of a stream
    default_cam();
    for (int i = 0; i < 6; i++) begin
      rand_pixel();
      step_clk("pre_rst");
    end
    #3 rst = 1'b1;
    #1 check_val("async_rst", 32'({red, green, blue}), 32'h0);
    for (int i = 0; i < LAT; i++) exp_pipe[i] = 24'h0;
    step_clk("rst_mid");
    step_clk("rst_mid");
    rst = 1'b0;
    pixel_x = 10'd320;
    pixel_y = 10'd240;
    for (int i = 0; i < LAT; i++) step_clk("rst_release");
    check_val("rst_first_hit", 32'({red, green, blue}), 32'(HIT_C));

    // Randomized cameras and pixels, changing every clock
    for (int i = 0; i < 400; i++) begin
      rand_cam();
      rand_pixel();
      step_clk("rand");
    end
    for (int i = 0; i < LAT; i++) begin
      rand_pixel();
      step_clk("drain");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
